// File: rtl/rr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// rr_lock_arbiter
//    Round-robin arbiter with grant locking. One shared resource is handed to
//    one of WIDTH requesters. The owner keeps the grant while its request
//    stays high. An optional hold timeout (MAX_HOLD != 0) pre-empts an owner
//    that has held the resource for MAX_HOLD cycles while others are waiting.
//
//    Parameters
//       WIDTH     number of requesters (>= 2, need not be a power of two)
//       MAX_HOLD  max consecutive grant cycles while others wait, 0 = never
//
//    Ports
//       clock        in   rising-edge clock
//       reset        in   asynchronous active-high reset
//       requests     in   [WIDTH-1:0] per-requester request
//       grant        out  [WIDTH-1:0] registered one-hot grant, 0 = no owner
//       grant_id     out  [IDW-1:0]   binary index of the granted requester
//       grant_valid  out  exactly one grant bit is set
//
// one_hot_decoder
//    Converts a one-hot vector into its binary index and flags whether the
//    vector holds exactly one set bit.
//
//    Ports
//       onehot  in   [WIDTH-1:0] one-hot input
//       index   out  [IDW-1:0]   index of the set bit (0 when none set)
//       valid   out  exactly one bit of onehot is set
// ---------------------------------------------------------------------------

module one_hot_decoder #(
   parameter int WIDTH = 8,
   parameter int IDW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] onehot,
   output logic [IDW-1:0]   index,
   output logic             valid
);

   // OR together the indices of all set bits; for a true one-hot input this
   // is exactly the index of the single set bit.
   always_comb begin
      index = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (onehot[i]) begin
            index = index | IDW'(i);
         end
      end
      valid = ($countones(onehot) == 1);
   end

endmodule

module rr_lock_arbiter #(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 0
) (
   input  logic                                       clock,
   input  logic                                       reset,
   input  logic [WIDTH-1:0]                           requests,
   output logic [WIDTH-1:0]                           grant,
   output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] grant_id,
   output logic                                       grant_valid
);

   localparam int IDW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // Without a timeout the hold counter only needs to saturate somewhere,
   // so an 8-bit counter pinned at all ones is enough.
   localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 8;
   localparam logic [HCW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HCW{1'b1}} : HCW'(MAX_HOLD);
   localparam logic [IDW-1:0] LAST_IDX = IDW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      GRANTED
   } state_t;

   state_t           state;
   logic [IDW-1:0]   pointer;
   logic [HCW-1:0]   hold_count;

   logic             owner_active;
   logic             others_pending;
   logic [WIDTH-1:0] candidates;
   logic             pick_valid;
   logic [IDW-1:0]   pick_idx;
   logic [WIDTH-1:0] pick_onehot;
   logic [IDW-1:0]   next_pointer;

   // The owner is never a candidate once granted: a pre-emption must move
   // the grant elsewhere, and on release its request bit is already low.
   always_comb begin
      owner_active   = |(requests & grant);
      others_pending = |(requests & ~grant);
      candidates     = (state == IDLE) ? requests : (requests & ~grant);
   end

   // Rotating priority search starting at pointer. The wrap is done
   // explicitly so non-power-of-two WIDTH values search correctly.
   always_comb begin
      int idx;
      pick_valid  = 1'b0;
      pick_idx    = '0;
      pick_onehot = '0;
      idx         = 0;
      for (int k = 0; k < WIDTH; k++) begin
         idx = int'(pointer) + k;
         if (idx >= WIDTH) begin
            idx = idx - WIDTH;
         end
         if (!pick_valid && candidates[idx]) begin
            pick_valid       = 1'b1;
            pick_idx         = IDW'(idx);
            pick_onehot[idx] = 1'b1;
         end
      end
      next_pointer = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDW'(1);
   end

   // Arbitration state machine. The grant only moves on a fresh grant from
   // idle, a timeout pre-emption, or a release; the new winner then becomes
   // lowest priority by placing the pointer just after it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= '0;
         pointer    <= '0;
         hold_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant      <= pick_onehot;
                  state      <= GRANTED;
                  pointer    <= next_pointer;
                  hold_count <= HCW'(1);
               end
            end
            GRANTED: begin
               if (owner_active) begin
                  if ((MAX_HOLD != 0) && (hold_count == HOLD_SAT) && others_pending) begin
                     grant      <= pick_onehot;
                     pointer    <= next_pointer;
                     hold_count <= HCW'(1);
                  end else if (hold_count != HOLD_SAT) begin
                     hold_count <= hold_count + HCW'(1);
                  end
               end else if (pick_valid) begin
                  grant      <= pick_onehot;
                  pointer    <= next_pointer;
                  hold_count <= HCW'(1);
               end else begin
                  grant      <= '0;
                  state      <= IDLE;
                  hold_count <= '0;
               end
            end
            default: begin
               state      <= IDLE;
               grant      <= '0;
               hold_count <= '0;
            end
         endcase
      end
   end

   one_hot_decoder #(
      .WIDTH (WIDTH),
      .IDW   (IDW)
   ) u_decoder (
      .onehot (grant),
      .index  (grant_id),
      .valid  (grant_valid)
   );

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_lock_arbiter
//    Directed bench for rr_lock_arbiter. Three instances: WIDTH=8 without
//    timeout, WIDTH=8 with MAX_HOLD=4, and WIDTH=5 without timeout. Inputs
//    change 1 ns after the rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------

module tb_rr_lock_arbiter;

   logic       clock;
   logic       reset;

   logic [7:0] req_a;
   logic [7:0] grant_a;
   logic [2:0] id_a;
   logic       valid_a;

   logic [7:0] req_t;
   logic [7:0] grant_t;
   logic [2:0] id_t;
   logic       valid_t;

   logic [4:0] req_w;
   logic [4:0] grant_w;
   logic [2:0] id_w;
   logic       valid_w;

   int checks;
   int failures;

   rr_lock_arbiter #(.WIDTH(8), .MAX_HOLD(0)) dut_a (
      .clock       (clock),
      .reset       (reset),
      .requests    (req_a),
      .grant       (grant_a),
      .grant_id    (id_a),
      .grant_valid (valid_a)
   );

   rr_lock_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut_t (
      .clock       (clock),
      .reset       (reset),
      .requests    (req_t),
      .grant       (grant_t),
      .grant_id    (id_t),
      .grant_valid (valid_t)
   );

   rr_lock_arbiter #(.WIDTH(5), .MAX_HOLD(0)) dut_w (
      .clock       (clock),
      .reset       (reset),
      .requests    (req_w),
      .grant       (grant_w),
      .grant_id    (id_w),
      .grant_valid (valid_w)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      req_a = '0;
      req_t = '0;
      req_w = '0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Power-up reset leaves every instance with no owner.
   task automatic test_reset();
      reset = 1'b1;
      req_a = '0;
      req_t = '0;
      req_w = '0;
      #1;
      checks++;
      if (grant_a !== 8'h00 || id_a !== 3'd0 || valid_a !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_a: grant=%b id=%0d valid=%b, expected 00000000 0 0", grant_a, id_a, valid_a);
      end
      checks++;
      if (grant_t !== 8'h00 || id_t !== 3'd0 || valid_t !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_t: grant=%b id=%0d valid=%b, expected 00000000 0 0", grant_t, id_t, valid_t);
      end
      checks++;
      if (grant_w !== 5'b00000 || id_w !== 3'd0 || valid_w !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_w: grant=%b id=%0d valid=%b, expected 00000 0 0", grant_w, id_w, valid_w);
      end
      tick();
      reset = 1'b0;
   endtask

   // Owner keeps the grant while its request stays high, then hands off.
   task automatic test_basic_lock();
      do_reset();
      req_a = 8'b00010100;
      tick();
      checks++;
      if (id_a !== 3'd2 || grant_a !== 8'b00000100) begin
         failures++;
         $display("[TB] FAIL lock_first: grant=%b id=%0d, expected 00000100 2", grant_a, id_a);
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (id_a !== 3'd2 || valid_a !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lock_hold cycle %0d: id=%0d valid=%b, expected 2 1", c, id_a, valid_a);
         end
      end
      req_a = 8'b00010000;
      tick();
      checks++;
      if (grant_a !== 8'b00010000 || id_a !== 3'd4 || valid_a !== 1'b1) begin
         failures++;
         $display("[TB] FAIL lock_handoff: grant=%b id=%0d valid=%b, expected 00010000 4 1", grant_a, id_a, valid_a);
      end
   endtask

   // Everyone requests; each owner drops out for one cycle after winning.
   task automatic test_fairness();
      do_reset();
      req_a = 8'hFF;
      tick();
      checks++;
      if (id_a !== 3'd0 || valid_a !== 1'b1) begin
         failures++;
         $display("[TB] FAIL fair_start: id=%0d valid=%b, expected 0 1", id_a, valid_a);
      end
      for (int k = 1; k <= 8; k++) begin
         req_a = 8'hFF & ~grant_a;
         tick();
         checks++;
         if (id_a !== 3'(k % 8) || valid_a !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fair_step %0d: id=%0d valid=%b, expected %0d 1", k, id_a, valid_a, k % 8);
         end
      end
   endtask

   // Releasing with nobody waiting returns to idle; a later request restarts.
   task automatic test_empty_release();
      do_reset();
      req_a = 8'b00100000;
      tick();
      checks++;
      if (id_a !== 3'd5 || grant_a !== 8'b00100000) begin
         failures++;
         $display("[TB] FAIL empty_grant: grant=%b id=%0d, expected 00100000 5", grant_a, id_a);
      end
      req_a = 8'h00;
      tick();
      checks++;
      if (grant_a !== 8'h00 || id_a !== 3'd0 || valid_a !== 1'b0) begin
         failures++;
         $display("[TB] FAIL empty_idle: grant=%b id=%0d valid=%b, expected 00000000 0 0", grant_a, id_a, valid_a);
      end
      req_a = 8'b00000001;
      tick();
      checks++;
      if (id_a !== 3'd0 || grant_a !== 8'b00000001 || valid_a !== 1'b1) begin
         failures++;
         $display("[TB] FAIL empty_regrant: grant=%b id=%0d valid=%b, expected 00000001 0 1", grant_a, id_a, valid_a);
      end
   endtask

   // MAX_HOLD=4: two constant requesters alternate every 4 cycles; a lone
   // requester is never pre-empted.
   task automatic test_timeout();
      logic [2:0] exp_id;
      do_reset();
      req_t = 8'b00000011;
      for (int c = 0; c < 16; c++) begin
         tick();
         exp_id = ((c / 4) % 2 == 0) ? 3'd0 : 3'd1;
         checks++;
         if (id_t !== exp_id || valid_t !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_alt cycle %0d: id=%0d valid=%b, expected %0d 1", c, id_t, valid_t, exp_id);
         end
      end
      req_t = 8'b00000001;
      tick();
      req_t = 8'b00000001;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if (id_t !== 3'd0 || grant_t !== 8'b00000001) begin
            failures++;
            $display("[TB] FAIL timeout_solo cycle %0d: grant=%b id=%0d, expected 00000001 0", c, grant_t, id_t);
         end
      end
   endtask

   // WIDTH=5: pointer after granting 4 wraps to 0.
   task automatic test_wrap();
      do_reset();
      req_w = 5'b10001;
      tick();
      checks++;
      if (grant_w !== 5'b00001 || id_w !== 3'd0) begin
         failures++;
         $display("[TB] FAIL wrap_first: grant=%b id=%0d, expected 00001 0", grant_w, id_w);
      end
      req_w = 5'b10000;
      tick();
      checks++;
      if (grant_w !== 5'b10000 || id_w !== 3'd4) begin
         failures++;
         $display("[TB] FAIL wrap_to4: grant=%b id=%0d, expected 10000 4", grant_w, id_w);
      end
      req_w = 5'b00011;
      tick();
      checks++;
      if (grant_w !== 5'b00001 || id_w !== 3'd0 || valid_w !== 1'b1) begin
         failures++;
         $display("[TB] FAIL wrap_to0: grant=%b id=%0d valid=%b, expected 00001 0 1", grant_w, id_w, valid_w);
      end
      req_w = 5'b10000;
      tick();
      checks++;
      if (grant_w !== 5'b10000 || id_w !== 3'd4) begin
         failures++;
         $display("[TB] FAIL wrap_back4: grant=%b id=%0d, expected 10000 4", grant_w, id_w);
      end
   endtask

   // Reset asserted between edges clears the grant immediately; the pointer
   // restarts at 0 so requester 3 beats requester 7 afterwards.
   task automatic test_reset_midsim();
      do_reset();
      req_a = 8'b00001000;
      tick();
      checks++;
      if (grant_a !== 8'b00001000) begin
         failures++;
         $display("[TB] FAIL midrst_setup: grant=%b, expected 00001000", grant_a);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (grant_a !== 8'h00 || id_a !== 3'd0 || valid_a !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrst_async: grant=%b id=%0d valid=%b, expected 00000000 0 0", grant_a, id_a, valid_a);
      end
      #1;
      reset = 1'b0;
      req_a = 8'b10001000;
      tick();
      checks++;
      if (grant_a !== 8'b00001000 || id_a !== 3'd3 || valid_a !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midrst_regrant: grant=%b id=%0d valid=%b, expected 00001000 3 1", grant_a, id_a, valid_a);
      end
   endtask

   // Test sequence.
   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic_lock();
      test_fairness();
      test_empty_release();
      test_timeout();
      test_wrap();
      test_reset_midsim();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
